mux_arb: RTL and testbench

Parametrised N-to-1 registered stream multiplexer with valid/ready handshaking and three selection modes: direct select, fixed priority, and round-robin. It succeeds the combinational 8:1 mux where several producers share one consumer. Examples are register-file read ports, bus masters, and ALU operand sources. It adds backpressure, arbitration and a one-deep output register.

---
 rtl/mux_pkg.sv | 9 +
 rtl/rr_arbiter.sv | 54 +++++
 rtl/mux_arb.sv | 82 ++++++++
 tb/tb_mux_arb.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared selection-mode encodings for the stream multiplexer and the
// decoder that drives its mode input.
package mux_pkg;

  localparam logic [1:0] MODE_DIRECT = 2'b00;
  localparam logic [1:0] MODE_PRIO   = 2'b01;
  localparam logic [1:0] MODE_RR     = 2'b10;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational channel selector: direct index, lowest-index priority, or
// round-robin search starting at ptr. Produces at most one grant.
module rr_arbiter
  import mux_pkg::*;
#(
  parameter int NUM_IN    = 8,
  parameter int SEL_WIDTH = $clog2(NUM_IN)
) (
  input  logic [NUM_IN-1:0]    in_valid,
  input  logic [SEL_WIDTH-1:0] ptr,
  input  logic [1:0]           mode,
  input  logic [SEL_WIDTH-1:0] sel,
  output logic [SEL_WIDTH-1:0] grant,
  output logic                 grant_valid
);

  localparam int IW = SEL_WIDTH + 1;

  logic [IW-1:0] idx_s;
  logic          hit_s;

  // Grant selection; the first hit in search order wins, later hits are masked.
  always_comb begin
    grant       = {SEL_WIDTH{1'b0}};
    grant_valid = 1'b0;
    idx_s       = {IW{1'b0}};
    hit_s       = 1'b0;
    case (mode)
      MODE_PRIO: begin
        for (int i = 0; i < NUM_IN; i++) begin
          hit_s       = !grant_valid && in_valid[i];
          grant       = hit_s ? SEL_WIDTH'(i) : grant;
          grant_valid = grant_valid | hit_s;
        end
      end
      MODE_RR: begin
        for (int i = 0; i < NUM_IN; i++) begin
          // ptr < NUM_IN, so one conditional subtract is enough to wrap
          idx_s       = IW'(ptr) + IW'(i);
          idx_s       = (idx_s >= IW'(NUM_IN)) ? (idx_s - IW'(NUM_IN)) : idx_s;
          hit_s       = !grant_valid && in_valid[idx_s[SEL_WIDTH-1:0]];
          grant       = hit_s ? idx_s[SEL_WIDTH-1:0] : grant;
          grant_valid = grant_valid | hit_s;
        end
      end
      default: begin
        hit_s       = (IW'(sel) < IW'(NUM_IN)) && in_valid[sel];
        grant       = hit_s ? sel : {SEL_WIDTH{1'b0}};
        grant_valid = hit_s;
      end
    endcase
  end

endmodule

// File: rtl/mux_arb.sv
// N-to-1 registered stream multiplexer with valid/ready handshaking and
// direct / fixed-priority / round-robin channel selection.
module mux_arb
  import mux_pkg::*;
#(
  parameter  int DATA_WIDTH = 8,
  parameter  int NUM_IN     = 8,
  localparam int SEL_WIDTH  = $clog2(NUM_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_IN*DATA_WIDTH-1:0] in,
  input  logic [NUM_IN-1:0]            in_valid,
  output logic [NUM_IN-1:0]            in_ready,
  input  logic [1:0]                   mode,
  input  logic [SEL_WIDTH-1:0]         sel,
  output logic [DATA_WIDTH-1:0]        out,
  output logic [SEL_WIDTH-1:0]         out_ch,
  output logic                         out_valid,
  input  logic                         out_ready
);

  logic [DATA_WIDTH-1:0] out_r;
  logic [SEL_WIDTH-1:0]  out_ch_r;
  logic                  out_valid_r;
  logic [SEL_WIDTH-1:0]  ptr_r;
  logic [SEL_WIDTH-1:0]  grant_s;
  logic                  grant_valid_s;
  logic                  load_s;
  logic                  xfer_s;
  logic [NUM_IN-1:0]     in_ready_s;

  rr_arbiter #(
    .NUM_IN    (NUM_IN),
    .SEL_WIDTH (SEL_WIDTH)
  ) u_arb (
    .in_valid    (in_valid),
    .ptr         (ptr_r),
    .mode        (mode),
    .sel         (sel),
    .grant       (grant_s),
    .grant_valid (grant_valid_s)
  );

  // rst_n gates load so no handshake is offered while reset is held.
  assign load_s = rst_n && (!out_valid_r || out_ready);
  assign xfer_s = load_s && grant_valid_s;

  // One-hot ready for the granted channel when the output register can load.
  always_comb begin
    in_ready_s = {NUM_IN{1'b0}};
    if (xfer_s) begin
      in_ready_s[grant_s] = 1'b1;
    end else begin
      in_ready_s = {NUM_IN{1'b0}};
    end
  end

  // Output register and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_r       <= {DATA_WIDTH{1'b0}};
      out_ch_r    <= {SEL_WIDTH{1'b0}};
      out_valid_r <= 1'b0;
      ptr_r       <= {SEL_WIDTH{1'b0}};
    end else if (xfer_s) begin
      out_r       <= in[int'(grant_s)*DATA_WIDTH +: DATA_WIDTH];
      out_ch_r    <= grant_s;
      out_valid_r <= 1'b1;
      ptr_r       <= (grant_s == SEL_WIDTH'(NUM_IN-1)) ? {SEL_WIDTH{1'b0}}
                                                       : (grant_s + SEL_WIDTH'(1));
    end else if (out_ready) begin
      out_valid_r <= 1'b0;
    end
  end

  assign in_ready  = in_ready_s;
  assign out       = out_r;
  assign out_ch    = out_ch_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_mux_arb.sv
// Scoreboard bench for mux_arb (8 x 8-bit): words are queued when the model
// predicts a transfer and popped when the consumer takes them.
module tb_mux_arb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] in;
  logic [7:0]  in_valid;
  logic [7:0]  in_ready;
  logic [1:0]  mode;
  logic [2:0]  sel;
  logic [7:0]  out;
  logic [2:0]  out_ch;
  logic        out_valid;
  logic        out_ready;

  int          total = 0;
  int          bad   = 0;
  int          mptr  = 0;
  logic        mfull = 1'b0;
  logic [10:0] sb_q[$];

  always #5 clk = ~clk;

  mux_arb #(.DATA_WIDTH(8), .NUM_IN(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .mode      (mode),
    .sel       (sel),
    .out       (out),
    .out_ch    (out_ch),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  task automatic set_data(input logic [7:0] base);
    for (int k = 0; k < 8; k++) in[k*8 +: 8] = base + 8'(k);
  endtask

  task automatic model_grant(output logic [2:0] g, output logic gv);
    g  = 3'd0;
    gv = 1'b0;
    if (mode == 2'b01) begin
      for (int i = 0; i < 8; i++)
        if (!gv && in_valid[i]) begin gv = 1'b1; g = 3'(i); end
    end else if (mode == 2'b10) begin
      for (int j = 0; j < 8; j++) begin
        int k;
        k = (mptr + j) % 8;
        if (!gv && in_valid[k]) begin gv = 1'b1; g = 3'(k); end
      end
    end else if (in_valid[sel]) begin
      gv = 1'b1;
      g  = sel;
    end
  endtask

  // One clock: checks at the negedge, then returns 1 time unit after the posedge.
  task automatic cycle();
    logic [2:0]  g;
    logic        gv;
    logic [10:0] e;
    logic [7:0]  er;
    @(negedge clk);
    total++;
    if (out_valid !== mfull) begin
      bad++; $display("FAIL out_valid_model got=%b exp=%b t=%0t", out_valid, mfull, $time);
    end
    if (mfull && out_ready) begin
      total++;
      if (sb_q.size() == 0) begin
        bad++; $display("FAIL sb_pop queue empty, got ch=%0d data=%h", out_ch, out);
      end else begin
        e = sb_q.pop_front();
        if ({out_ch, out} !== e) begin
          bad++; $display("FAIL sb_word got ch=%0d data=%h exp ch=%0d data=%h",
                          out_ch, out, e[10:8], e[7:0]);
        end
      end
    end
    model_grant(g, gv);
    er = ((!mfull || out_ready) && gv) ? (8'b1 << g) : 8'b0;
    total++;
    if (in_ready !== er) begin
      bad++; $display("FAIL in_ready got=%b exp=%b t=%0t", in_ready, er, $time);
    end
    if ((!mfull || out_ready) && gv) begin
      sb_q.push_back({g, in[int'(g)*8 +: 8]});
      mfull = 1'b1;
      mptr  = (g == 3'd7) ? 0 : int'(g) + 1;
    end else if (out_ready) begin
      mfull = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1; in_valid = 8'hFF; out_ready = 1'b1; mode = 2'b10; sel = 3'd0;
    set_data(8'h10);
    #2 rst_n = 1'b0;
    @(posedge clk); #1;
    total++;
    if (out !== 8'h00 || out_ch !== 3'd0 || out_valid !== 1'b0) begin
      bad++; $display("FAIL reset_out got out=%h ch=%0d v=%b exp 00/0/0", out, out_ch, out_valid);
    end
    total++;
    if (in_ready !== 8'h00) begin
      bad++; $display("FAIL reset_ready got=%b exp=00000000", in_ready);
    end
    in_valid = 8'h00;
    @(posedge clk); #1;
    rst_n = 1'b1; mptr = 0; mfull = 1'b0; sb_q.delete();
    cycle(); cycle();
    total++;
    if (out_valid !== 1'b0) begin
      bad++; $display("FAIL idle_valid got=%b exp=0", out_valid);
    end
  endtask

  task automatic test_direct();
    mode = 2'b00; sel = 3'd5; in_valid = 8'hFF; out_ready = 1'b1;
    set_data(8'h00); in[47:40] = 8'hA5;
    cycle();
    total++;
    if (out !== 8'hA5 || out_ch !== 3'd5) begin
      bad++; $display("FAIL direct_word got %h/%0d exp a5/5", out, out_ch);
    end
    sel = 3'd7; in_valid = 8'h7F;
    cycle();
    total++;
    if (out_valid !== 1'b0 || in_ready !== 8'h00) begin
      bad++; $display("FAIL direct_none got v=%b rdy=%b exp 0/00000000", out_valid, in_ready);
    end
  endtask

  task automatic test_priority();
    logic [2:0] exp_ch[3];
    exp_ch[0] = 3'd2; exp_ch[1] = 3'd4; exp_ch[2] = 3'd7;
    mode = 2'b01; set_data(8'h20); in_valid = 8'b1001_0100; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      total++;
      if (out_ch !== exp_ch[i] || out !== 8'h20 + 8'(exp_ch[i])) begin
        bad++; $display("FAIL prio_%0d got %0d/%h exp %0d", i, out_ch, out, exp_ch[i]);
      end
      in_valid[exp_ch[i]] = 1'b0;
    end
    cycle();
  endtask

  task automatic test_round_robin();
    logic [2:0] e;
    mode = 2'b10; set_data(8'h10); in_valid = 8'hFF; out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      total++;
      if (out !== 8'h10 + 8'(i % 8)) begin
        bad++; $display("FAIL rr_seq_%0d got=%h exp=%h", i, out, 8'h10 + 8'(i % 8));
      end
    end
    // pointer now sits at 2, so the search reaches channel 6 first
    in_valid = 8'b0100_0010;
    for (int i = 0; i < 4; i++) begin
      cycle();
      e = (i % 2 == 0) ? 3'd6 : 3'd1;
      total++;
      if (out_ch !== e) begin
        bad++; $display("FAIL rr_pair_%0d got=%0d exp=%0d", i, out_ch, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] hold_out;
    logic [2:0] hold_ch;
    mode = 2'b10; set_data(8'h40); in_valid = 8'hFF; out_ready = 1'b1;
    cycle();
    hold_out = out; hold_ch = out_ch;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cycle();
      total++;
      if (out !== hold_out || out_ch !== hold_ch || out_valid !== 1'b1 || in_ready !== 8'h00) begin
        bad++; $display("FAIL bp_hold_%0d got %h/%0d v=%b rdy=%b exp %h/%0d v=1 rdy=0",
                        i, out, out_ch, out_valid, in_ready, hold_out, hold_ch);
      end
    end
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    for (int i = 0; i < 40; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      in_valid  = 8'($urandom);
      mode      = 2'($urandom_range(0, 3));
      sel       = 3'($urandom_range(0, 7));
      set_data(8'($urandom));
      cycle();
    end
    in_valid = 8'h00; out_ready = 1'b1;
    cycle(); cycle();
    total++;
    if (sb_q.size() != 0) begin
      bad++; $display("FAIL sb_left got=%0d exp=0", sb_q.size());
    end
  endtask

  task automatic test_async_reset();
    mode = 2'b10; set_data(8'h60); in_valid = 8'hFF; out_ready = 1'b1;
    cycle();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if (out_valid !== 1'b0 || out !== 8'h00 || out_ch !== 3'd0 || in_ready !== 8'h00) begin
      bad++; $display("FAIL async_rst got v=%b out=%h ch=%0d rdy=%b exp 0/00/0/0",
                      out_valid, out, out_ch, in_ready);
    end
    sb_q.delete(); mfull = 1'b0; mptr = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cycle();
      total++;
      if (out_ch !== 3'(i) || out !== 8'h60 + 8'(i)) begin
        bad++; $display("FAIL rr_restart_%0d got %0d/%h exp %0d/%h", i, out_ch, out, i, 8'h60 + 8'(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_direct();
    test_priority();
    test_round_robin();
    test_back_to_back();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
